// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: broadcast record, tag width, default source count, tag matcher.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
`timescale 1ns/1ps
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int N_FU_SRC   = 4;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  // Consumers (RS, ROB, regfile) wake up on a valid broadcast carrying their tag.
  function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
    return bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: search starts at rr_ptr and wraps modulo N.
// Latency: purely combinational.
// Backpressure: none; the pointer register lives in the caller.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         gnt
);

  int   idx;
  logic found;

  // First set request at or after rr_ptr (circularly) wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(rr_ptr) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus producer: one-entry buffer per FU, round-robin onto a registered cdb.
// Latency: 2 cycles accept->broadcast; 1 cycle for a bypass winner when CDB_BYPASS_EN is defined.
// Backpressure: src_ready drops while a source's buffer is full and not granted, and during flush.
`timescale 1ns/1ps
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = N_FU_SRC
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  flush,
  input  logic [N_SRC-1:0]                      src_valid,
  input  logic [N_SRC-1:0][ROB_WIDTH-1:0]       src_tag,
  input  logic [N_SRC-1:0][DATA_WIDTH-1:0]      src_data,
  output logic [N_SRC-1:0]                      src_ready,
  output cdb_t                                  cdb
);

  localparam int PTR_W = $clog2(N_SRC);

  logic [N_SRC-1:0]                 pend_q, pend_d;
  logic [N_SRC-1:0][ROB_WIDTH-1:0]  tag_q;
  logic [N_SRC-1:0][DATA_WIDTH-1:0] data_q;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  cdb_t                             cdb_q, cdb_d;

  logic [N_SRC-1:0] req, gnt, acc;
  logic [PTR_W-1:0] win_idx;
  logic             any_gnt;

`ifdef CDB_BYPASS_EN
  // An empty buffer lets its live inputs compete directly.
  assign req = pend_q | (src_valid & ~pend_q);
`else
  assign req = pend_q;
`endif

  rr_arbiter #(.N(N_SRC)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt)
  );

  // A granted source frees its slot this cycle, so it may refill immediately.
  assign src_ready = flush ? '0 : (~pend_q | gnt);
  assign acc       = src_valid & src_ready;
  assign cdb       = cdb_q;

  // Encode the one-hot grant into the winning source index.
  always_comb begin
    win_idx = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        win_idx = PTR_W'(i);
        any_gnt = 1'b1;
      end
    end
  end

  // Next-state for pending flags, pointer and the broadcast register.
  always_comb begin
    // Keep ungranted entries; take new accepts except a bypass winner, which goes out directly.
    pend_d   = (pend_q & ~gnt) | (acc & ~(gnt & ~pend_q));
    rr_ptr_d = rr_ptr_q;
    cdb_d    = cdb_q;
    cdb_d.valid = 1'b0;
    if (flush) begin
      pend_d = '0;
    end else if (any_gnt) begin
      rr_ptr_d    = (int'(win_idx) == N_SRC - 1) ? '0 : win_idx + 1'b1;
      cdb_d.valid = 1'b1;
`ifdef CDB_BYPASS_EN
      if (pend_q[win_idx]) begin
        cdb_d.tag  = tag_q[win_idx];
        cdb_d.data = data_q[win_idx];
      end else begin
        cdb_d.tag  = src_tag[win_idx];
        cdb_d.data = src_data[win_idx];
      end
`else
      cdb_d.tag  = tag_q[win_idx];
      cdb_d.data = data_q[win_idx];
`endif
    end
  end

  // State registers; holding registers capture every accepted result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q   <= '0;
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      for (int i = 0; i < N_SRC; i++) begin
        if (acc[i]) begin
          tag_q[i]  <= src_tag[i];
          data_q[i] <= src_data[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scoreboard of expected broadcasts plus direct checks.
// Latency: n/a.
// Backpressure: sources advance only on observed valid&ready.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

`ifdef CDB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic                              clk = 1'b0;
  logic                              rstn;
  logic                              flush;
  logic [3:0]                        src_valid;
  logic [3:0][ROB_WIDTH-1:0]         src_tag;
  logic [3:0][DATA_WIDTH-1:0]        src_data;
  logic [3:0]                        src_ready;
  cdb_t                              cdb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] sb[$];
  logic [35:0] mon_exp;

  int         c0, c2, s, waited, start;
  logic [3:0] tb_acc, exp_rdy;

  cdb_arbiter #(.N_SRC(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb       (cdb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [3:0] tag, input logic [31:0] data);
    sb.push_back({tag, data});
  endtask

  task automatic do_reset();
    src_valid = '0;
    flush     = 1'b0;
    rstn      = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Every valid broadcast must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && cdb.valid) begin
      if (sb.size() == 0) begin
        chk("cdb_unexpected_valid", 64'(cdb.valid), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("cdb_bcast", 64'({cdb.tag, cdb.data}), 64'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    src_tag  = '0;
    src_data = '0;
    src_valid = '0;
    flush = 1'b0;
    rstn  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_cdb_valid", 64'(cdb.valid), 64'd0);
    chk("reset_cdb_tag",   64'(cdb.tag),   64'd0);
    chk("reset_cdb_data",  64'(cdb.data),  64'd0);
    chk("reset_ready",     64'(src_ready), 64'hF);
    @(negedge clk);
    rstn = 1'b1;

    // Single accept from src1.
    @(negedge clk);
    src_valid = 4'b0010; src_tag[1] = 4'd3; src_data[1] = 32'hDEADBEEF;
    exp_push(4'd3, 32'hDEADBEEF);
    @(negedge clk);
    src_valid = '0;
    chk("single_lat1_valid", 64'(cdb.valid), 64'(BYP));
    @(negedge clk);
    chk("single_lat2_valid", 64'(cdb.valid), 64'(1 - BYP));
    @(negedge clk);
    chk("single_idle_valid", 64'(cdb.valid), 64'd0);
    repeat (2) @(negedge clk);

    // All four at once from rr_ptr=0: tags 4..7 in order, ready fills back in.
    do_reset();
    @(negedge clk);
    src_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      src_tag[i]  = 4'(4 + i);
      src_data[i] = 32'hA000_0000 + 32'(4 + i);
      exp_push(4'(4 + i), 32'hA000_0000 + 32'(4 + i));
    end
    @(negedge clk);
    src_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      s = k + BYP;
      exp_rdy = (s >= 3) ? 4'hF : 4'((1 << (s + 1)) - 1);
      chk("all4_ready", 64'(src_ready), 64'(exp_rdy));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // src0 and src2 always valid: grants must alternate 0,2,0,2.
    for (int i = 0; i < 4; i++) begin
      exp_push(4'(2 * i),     32'h0C00_0000 + 32'(i));
      exp_push(4'(2 * i + 1), 32'h0C00_0200 + 32'(i));
    end
    c0 = 0; c2 = 0;
    for (int t = 0; t < 40 && (c0 < 4 || c2 < 4); t++) begin
      @(negedge clk);
      src_valid   = {1'b0, (c2 < 4), 1'b0, (c0 < 4)};
      src_tag[0]  = 4'(2 * c0);
      src_data[0] = 32'h0C00_0000 + 32'(c0);
      src_tag[2]  = 4'(2 * c2 + 1);
      src_data[2] = 32'h0C00_0200 + 32'(c2);
      #1;
      tb_acc = src_valid & src_ready;
      if (tb_acc[0]) c0++;
      if (tb_acc[2]) c2++;
    end
    chk("contention_accepts", 64'(c0 + c2), 64'd8);
    @(negedge clk);
    src_valid = '0;
    repeat (4) @(negedge clk);

    // Flush with three entries pending; pointer must survive the flush.
    src_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      src_tag[i]  = 4'(10 + i);
      src_data[i] = 32'hF100_0000 + 32'(i);
    end
    if (BYP == 1) exp_push(4'd10, 32'hF100_0000);
    @(negedge clk);
    src_valid = '0;
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(src_ready), 64'd0);
    chk("flush_cycle_valid", 64'(cdb.valid), 64'(BYP));
    @(negedge clk);
    flush = 1'b0;
    chk("post_flush_valid", 64'(cdb.valid), 64'd0);
    #1;
    chk("post_flush_ready", 64'(src_ready), 64'hF);
    start = (BYP == 1) ? 1 : 3;
    src_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      src_tag[i]  = 4'(12 + i);
      src_data[i] = 32'hB000_0000 + 32'(i);
    end
    for (int j = 0; j < 4; j++)
      exp_push(4'(12 + (start + j) % 4), 32'hB000_0000 + 32'((start + j) % 4));
    @(negedge clk);
    src_valid = '0;
    repeat (6) @(negedge clk);

    // Refill on grant: src2 granted while presenting tag 9.
    src_valid = 4'b0100; src_tag[2] = 4'd8; src_data[2] = 32'h0000_0888;
    exp_push(4'd8, 32'h0000_0888);
    @(negedge clk);
    src_tag[2] = 4'd9; src_data[2] = 32'h0000_0999;
    exp_push(4'd9, 32'h0000_0999);
    #1;
    chk("refill_ready", 64'(src_ready[2]), 64'd1);
    @(negedge clk);
    src_valid = '0;
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-cycle while a broadcast is on the bus.
    src_valid = 4'b1000; src_tag[3] = 4'd5; src_data[3] = 32'h5555_AAAA;
    exp_push(4'd5, 32'h5555_AAAA);
    @(negedge clk);
    src_valid = '0;
    waited = 0;
    while (!cdb.valid && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    chk("async_pre_valid", 64'(cdb.valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_valid", 64'(cdb.valid), 64'd0);
    chk("async_tag",   64'(cdb.tag),   64'd0);
    chk("async_data",  64'(cdb.data),  64'd0);
    chk("async_ready", 64'(src_ready), 64'hF);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer end of the common data bus. Collects completed results (ROB tag + 32-bit data) from N_SRC functional units, holds each in a one-entry per-source buffer, and drives exactly one `cdb_t` broadcast per cycle under round-robin arbitration. Sits between the execution units and every CDB consumer: reservation stations, ROB and register file, all matching via `tag_match`. Supports a pipeline-wide flush on branch misprediction.

## Interface
Parameters:
- N_SRC, 4, number of functional-unit result sources (≥2)
- ROB_WIDTH, package value (4), tag width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  discard all buffered and incoming results
- src_valid  in  N_SRC  result present from source i
- src_tag  in  N_SRC×ROB_WIDTH  ROB tag of source i
- src_data  in  N_SRC×32  result data of source i
- src_ready  out  N_SRC  source i result accepted this cycle when valid&ready
- cdb  out  cdb_t  registered broadcast (valid, tag, data)

## Operation
- Per source: `pend[i]` flag plus tag/data holding register.
- Accept: `src_valid[i] && src_ready[i]` loads the holding register and sets `pend[i]`.
- `src_ready[i] = !flush && (!pend[i] || gnt[i])`. A granted source refills in the same cycle.
- Request vector `req = pend`; bypass extension described under Configuration.
- Round-robin: search starts at `rr_ptr`, wraps modulo N_SRC, first set request wins (`gnt` one-hot). After any grant, `rr_ptr <= (winner+1) mod N_SRC`; with no grant, `rr_ptr` holds.
- Granted entry is registered into `cdb` (valid=1, tag, data) and its `pend` clears, unless refilled the same cycle.
- No request: `cdb.valid <= 0`; tag/data hold their previous values.
- Flush: `pend` cleared, `cdb.valid <= 0`, `src_ready` all 0, no inputs accepted, `rr_ptr` unchanged. A broadcast already registered in `cdb` during the flush cycle still appears. Consumers ignore it.
- Reset (asynchronous, any time including mid-transfer): `pend=0`, `rr_ptr=0`, `cdb.valid=0`, `cdb.tag=0`, `cdb.data=0`. `src_ready` then evaluates to all-1.
- The block does not detect duplicate tags; sources guarantee uniqueness.

## Timing
- Without bypass: accept at edge k, earliest broadcast visible after edge k+1 (2-cycle latency).
- Sustained throughput: one broadcast per cycle when any request is pending.
- Fairness: under full load, each source waits at most N_SRC−1 broadcasts.
- Back-to-back from one source: continuous accept plus grant every cycle is possible when it is the only requester.
- `cdb` is driven directly from flops; no combinational path from src_* to `cdb`.
- `src_ready` is combinational from `pend`, `gnt` and `flush`.

## Configuration
- `CDB_BYPASS_EN` defined:
  - `req = pend | (src_valid & ~pend)`.
  - An empty-buffer source is arbitrated directly from its inputs, using the same priority order.
  - Winning bypass inputs go straight to `cdb`, giving 1-cycle latency (accept at edge k, visible after edge k).
  - A losing bypass request is buffered as a normal accept.
- Undefined: `req = pend` only; fixed 2-cycle latency.

## Structure
- Shared package holds `cdb_t`, `tag_match` and ROB_WIDTH; add N_SRC default `N_FU_SRC` there.
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: `req`, `rr_ptr`
  - output: one-hot `gnt`
  - purely combinational
- Pointer register, buffers and `cdb` register stay in `cdb_arbiter`.

## Test plan
- Reset release, single accept: src1 valid tag=3 data=0xDEADBEEF at edge 0 → cdb {1,3,0xDEADBEEF} after edge 1 (after edge 0 with CDB_BYPASS_EN); cdb.valid=0 the following cycle.
- All four sources valid simultaneously, tags 4..7, `rr_ptr=0` → broadcasts tag 4,5,6,7 on consecutive cycles; src_ready deasserts for the pending sources until each is granted.
- Sustained contention, src0 and src2 always valid → grants alternate 0,2,0,2; neither starves.
- Flush with three entries pending → cdb.valid=0 next cycle, all pend cleared, src_ready=0 during flush, rr_ptr unchanged.
- Asynchronous rstn low mid-cycle with cdb.valid=1 → cdb.valid=0, tag=0, data=0 immediately, before the next clock edge.
- Refill on grant: src2 pending and granted while src_valid[2]=1 with tag=9 → src_ready[2]=1, tag 9 buffered, broadcast in the next eligible round.
